// File: rtl/dfr_input_masker.sv
// Input masking stage for the delay-feedback reservoir.
// Each accepted sample is scaled by a per-virtual-node Q0.MASK_WIDTH mask.
// The scaled value is truncated and saturated, then handed to the reservoir
// one node at a time. The stage throttles on the reservoir's valid/idle flag.
module dfr_input_masker #(
  parameter int unsigned              NUM_VIRTUAL_NODES = 10,
  parameter int unsigned              DATA_WIDTH        = 32,
  parameter int unsigned              SAMPLE_WIDTH      = 16,
  parameter int unsigned              MASK_WIDTH        = 8,
  parameter logic [SAMPLE_WIDTH-1:0]  CLAMP_MAX         = 16'h7FFF,
  parameter logic [MASK_WIDTH-1:0]    MASK_RESET        = 8'h80
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   sample_valid,
  output logic                                   sample_ready,
  input  logic [SAMPLE_WIDTH-1:0]                sample_data,
  input  logic                                   mask_wr_en,
  input  logic [$clog2(NUM_VIRTUAL_NODES)-1:0]   mask_wr_addr,
  input  logic [MASK_WIDTH-1:0]                  mask_wr_data,
  output logic [DATA_WIDTH-1:0]                  res_din,
  output logic                                   res_en,
  input  logic                                   res_valid,
  output logic [$clog2(NUM_VIRTUAL_NODES)-1:0]   node_idx,
  output logic                                   busy,
  output logic                                   sample_done
);

  localparam int unsigned NODE_W = $clog2(NUM_VIRTUAL_NODES);
  localparam int unsigned PROD_W = SAMPLE_WIDTH + MASK_WIDTH;
  localparam logic [NODE_W-1:0] LAST_NODE = NODE_W'(NUM_VIRTUAL_NODES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC,
    S_ISSUE,
    S_GUARD,
    S_WAIT_RES,
    S_DONE
  } state_e;

  state_e                  state_q;
  logic [SAMPLE_WIDTH-1:0] sample_q;
  logic [NODE_W-1:0]       node_q;
  logic [DATA_WIDTH-1:0]   din_q;
  logic                    en_q;
  logic                    done_q;
  logic                    ready_q;
  logic                    busy_q;
  logic [MASK_WIDTH-1:0]   mask_q [NUM_VIRTUAL_NODES];

  logic [PROD_W-1:0]       prod_c;
  logic [SAMPLE_WIDTH-1:0] scaled_c;
  logic [SAMPLE_WIDTH-1:0] clamped_c;

  // Mask table: writable in any state, out-of-range addresses dropped
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(NUM_VIRTUAL_NODES); i++) begin
        mask_q[i] <= MASK_RESET;
      end
    end else if (mask_wr_en && (32'(mask_wr_addr) < NUM_VIRTUAL_NODES)) begin
      mask_q[mask_wr_addr] <= mask_wr_data;
    end
  end

  // Scale current sample by current node mask: truncate fraction, then saturate
  always_comb begin
    prod_c    = PROD_W'(sample_q) * PROD_W'(mask_q[node_q]);
    scaled_c  = SAMPLE_WIDTH'(prod_c >> MASK_WIDTH);
    clamped_c = (scaled_c > CLAMP_MAX) ? CLAMP_MAX : scaled_c;
  end

  // Sequencer: one sample in, one masked value per node out, then a done pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      sample_q <= '0;
      node_q   <= '0;
      din_q    <= '0;
      en_q     <= 1'b0;
      done_q   <= 1'b0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      en_q   <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          if (sample_valid && ready_q) begin
            sample_q <= sample_data;
            node_q   <= '0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= S_CALC;
          end
        end
        S_CALC: begin
          din_q   <= DATA_WIDTH'(clamped_c);
          state_q <= S_ISSUE;
        end
        S_ISSUE: begin
          if (res_valid) begin
            en_q    <= 1'b1;
            state_q <= S_GUARD;
          end
        end
        // Reservoir drops its valid only after it has sampled en
        S_GUARD: begin
          state_q <= S_WAIT_RES;
        end
        S_WAIT_RES: begin
          if (res_valid) begin
            if (node_q == LAST_NODE) begin
              state_q <= S_DONE;
            end else begin
              node_q  <= node_q + NODE_W'(1);
              state_q <= S_CALC;
            end
          end
        end
        S_DONE: begin
          done_q  <= 1'b1;
          node_q  <= '0;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign sample_ready = ready_q;
  assign res_din      = din_q;
  assign res_en       = en_q;
  assign node_idx     = node_q;
  assign busy         = busy_q;
  assign sample_done  = done_q;

endmodule

// File: tb/tb_dfr_input_masker.sv
// Directed/randomized bench for dfr_input_masker with a stalling reservoir model.
module tb_dfr_input_masker;

  localparam int N = 10;

  logic        clk;
  logic        rst;
  logic        sample_valid;
  logic        sample_ready;
  logic [15:0] sample_data;
  logic        mask_wr_en;
  logic [3:0]  mask_wr_addr;
  logic [7:0]  mask_wr_data;
  logic [31:0] res_din;
  logic        res_en;
  logic        res_valid;
  logic [3:0]  node_idx;
  logic        busy;
  logic        sample_done;

  int          vectors;
  int          miscompares;
  int          stall_cfg;
  int          hold_cnt;
  logic [7:0]  mask_m [N];

  dfr_input_masker dut (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .sample_data  (sample_data),
    .mask_wr_en   (mask_wr_en),
    .mask_wr_addr (mask_wr_addr),
    .mask_wr_data (mask_wr_data),
    .res_din      (res_din),
    .res_en       (res_en),
    .res_valid    (res_valid),
    .node_idx     (node_idx),
    .busy         (busy),
    .sample_done  (sample_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reservoir: busy for stall_cfg cycles after each en it samples
  always @(posedge clk or negedge rst) begin
    if (!rst) hold_cnt <= 0;
    else if (res_en) hold_cnt <= stall_cfg;
    else if (hold_cnt > 0) hold_cnt <= hold_cnt - 1;
  end
  assign res_valid = (hold_cnt == 0);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_out(input logic [15:0] s, input logic [7:0] m);
    int unsigned p;
    p = 32'(s) * 32'(m);
    p = p / 256;
    if (p > 32'h7FFF) p = 32'h7FFF;
    return p;
  endfunction

  task automatic write_mask(input int addr, input logic [7:0] d);
    mask_wr_en   = 1'b1;
    mask_wr_addr = 4'(addr);
    mask_wr_data = d;
    @(negedge clk);
    mask_wr_en = 1'b0;
    if (addr < N) mask_m[addr] = d;
  endtask

  task automatic reset_model();
    for (int i = 0; i < N; i++) mask_m[i] = 8'h80;
  endtask

  // Drive one sample and follow it node by node; optional collision write or abort
  task automatic run_sample(input logic [15:0] s, input int stall, input bit keep_valid,
                            input logic [15:0] next_data, input int coll_node,
                            input logic [7:0] coll_val, input int abort_node);
    logic [31:0] exp [N];
    int  en_cnt;
    int  last_en;
    int  cyc;
    int  w;
    bit  got_done;
    bit  written;
    bit  seen_done;
    for (int i = 0; i < N; i++) exp[i] = ref_out(s, mask_m[i]);
    stall_cfg = stall;
    w = 0;
    while (!sample_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("ready_before_accept", sample_ready, 1);
    sample_valid = 1'b1;
    sample_data  = s;
    @(negedge clk);
    if (!keep_valid) sample_valid = 1'b0;
    else sample_data = next_data;
    cyc = 1; en_cnt = 0; last_en = -1; got_done = 0; written = 0;
    while (cyc < 2000 && !got_done) begin
      if (busy) check("ready_low_while_busy", sample_ready, 0);
      if (res_en) begin
        check("en_node_idx", node_idx, en_cnt);
        if (en_cnt < N) check("res_din", res_din, exp[en_cnt]);
        last_en = en_cnt;
        en_cnt++;
      end else if (last_en >= 0 && last_en < N && busy && node_idx == 4'(last_en)) begin
        check("res_din_hold", res_din, exp[last_en]);
      end
      if (coll_node > 0 && !written && node_idx == 4'(coll_node)) begin
        mask_wr_en   = 1'b1;
        mask_wr_addr = 4'(coll_node);
        mask_wr_data = coll_val;
        written      = 1;
      end else begin
        mask_wr_en = 1'b0;
      end
      if (abort_node >= 0 && node_idx == 4'(abort_node) && last_en == abort_node &&
          !res_valid && !res_en) begin
        #2 rst = 1'b0;
        #1;
        check("abort_res_en", res_en, 0);
        check("abort_res_din", res_din, 0);
        check("abort_busy", busy, 0);
        check("abort_ready", sample_ready, 0);
        check("abort_node_idx", node_idx, 0);
        check("abort_done", sample_done, 0);
        sample_valid = 1'b0;
        mask_wr_en   = 1'b0;
        reset_model();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        seen_done = 0;
        for (int k = 0; k < 50; k++) begin
          @(negedge clk);
          if (sample_done) seen_done = 1;
        end
        check("abort_no_done", seen_done, 0);
        return;
      end
      if (sample_done) got_done = 1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    mask_wr_en = 1'b0;
    check("done_seen", got_done, 1);
    check("en_count", en_cnt, N);
    check("done_node_idx", node_idx, 0);
    check("done_busy", busy, 0);
    if (stall == 0) check("latency", cyc - 1, 4 * N + 1);
    if (!keep_valid) begin
      @(negedge clk);
      check("done_one_cycle", sample_done, 0);
    end
  endtask

  initial begin
    vectors = 0; miscompares = 0; stall_cfg = 0;
    rst = 1'b0; sample_valid = 1'b0; sample_data = '0;
    mask_wr_en = 1'b0; mask_wr_addr = '0; mask_wr_data = '0;
    reset_model();

    // Reset state
    #3;
    check("rst_ready", sample_ready, 0);
    check("rst_res_en", res_en, 0);
    check("rst_res_din", res_din, 0);
    check("rst_busy", busy, 0);
    check("rst_done", sample_done, 0);
    check("rst_node_idx", node_idx, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("ready_after_rst", sample_ready, 1);

    // Default masks
    run_sample(16'h1000, 0, 0, 16'h0, 0, 8'h0, -1);

    // Per-node masks, including ignored out-of-range writes
    write_mask(0, 8'h00);
    write_mask(1, 8'h40);
    write_mask(2, 8'hFF);
    for (int i = 3; i < N; i++) write_mask(i, 8'($urandom_range(0, 255)));
    write_mask(12, 8'h11);
    write_mask(15, 8'h22);
    run_sample(16'h0400, 0, 0, 16'h0, 0, 8'h0, -1);

    // Saturation
    for (int i = 0; i < N; i++) write_mask(i, 8'hFF);
    run_sample(16'hFFFF, 0, 0, 16'h0, 0, 8'h0, -1);

    // Backpressure
    for (int i = 0; i < N; i++) write_mask(i, 8'($urandom_range(0, 255)));
    run_sample(16'($urandom), 3, 0, 16'h0, 0, 8'h0, -1);

    // Held valid across two samples, with a mask write colliding with node 2 CALC
    begin
      logic [15:0] b;
      b = 16'($urandom);
      run_sample(16'hABCD, 0, 1, b, 2, 8'h5A, -1);
      mask_m[2] = 8'h5A;
      run_sample(b, 0, 0, 16'h0, 0, 8'h0, -1);
    end

    // Randomized samples
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < N; i++) write_mask(i, 8'($urandom_range(0, 255)));
      run_sample(16'($urandom), $urandom_range(0, 3), 0, 16'h0, 0, 8'h0, -1);
    end

    // Reset during node 5 wait, then masks must be back to default
    for (int i = 0; i < N; i++) write_mask(i, 8'($urandom_range(0, 255)));
    run_sample(16'($urandom), 3, 0, 16'h0, 0, 8'h0, 5);
    run_sample(16'h1000, 0, 0, 16'h0, 0, 8'h0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
